// File: rtl/alu_pkg.sv
// Shared constants for alu_multicycle: default width, FSM state encoding and op codes.
// The M-extension datapath is built only when ALU_MULTICYCLE_MULDIV_EN is defined.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Base-op funct3; alu_ctrl[3] selects SUB for F3_ADD and SRA for F3_SR.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] M3_MUL    = 3'b000;
  localparam logic [2:0] M3_MULH   = 3'b001;
  localparam logic [2:0] M3_MULHSU = 3'b010;
  localparam logic [2:0] M3_MULHU  = 3'b011;
  localparam logic [2:0] M3_DIV    = 3'b100;
  localparam logic [2:0] M3_DIVU   = 3'b101;
  localparam logic [2:0] M3_REM    = 3'b110;
  localparam logic [2:0] M3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply/divide engine: WIDTH iterations on magnitudes, sign fixed at the end.
// Instantiated by alu_multicycle only when ALU_MULTICYCLE_MULDIV_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic             a_signed, b_signed, a_neg, b_neg, start_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_step, lo_step;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      M3_MULH, M3_DIV, M3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      M3_MULHSU: a_signed = 1'b1;
      M3_MUL, M3_MULHU, M3_DIVU, M3_REMU: ;
      default: ;
    endcase
    a_neg     = a_signed && a[WIDTH-1];
    b_neg     = b_signed && b[WIDTH-1];
    a_mag     = a_neg ? ('0 - a) : a;
    b_mag     = b_neg ? ('0 - b) : b;
    // Remainder takes the dividend's sign; every other result the product/quotient sign.
    start_neg = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_q, lo_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, opnd_q};
    div_ge   = !div_diff[WIDTH];
    if (op_q[2]) begin
      acc_step = div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      lo_step  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = {acc_step, lo_step};
    prod_s = neg_q ? ('0 - prod) : prod;
    quo_s  = neg_q ? ('0 - lo_step) : lo_step;
    rem_s  = neg_q ? ('0 - acc_step) : acc_step;
    if (op_q[2])
      result = op_q[1] ? rem_s : quo_s;
    else
      result = (op_q == M3_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
  end

  assign done = busy_q && (cnt_q == LAST);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    neg_d  = neg_q;
    acc_d  = acc_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (flush) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = op;
      neg_d  = start_neg;
      acc_d  = '0;
      lo_d   = op[2] ? a_mag : b_mag;
      opnd_d = op[2] ? b_mag : a_mag;
    end else if (busy_q) begin
      acc_d = acc_step;
      lo_d  = lo_step;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: datapath registers carry no reset; start always loads them before they are read.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg_q  <= neg_d;
    acc_q  <= acc_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
  end

endmodule

// File: rtl/alu_multicycle.sv
// RV32I-style ALU with valid/ready handshake; base ops finish in one cycle, M ops iterate.
// Define ALU_MULTICYCLE_MULDIV_EN to build the multiply/divide datapath; otherwise M ops flag illegal.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  input  logic             m_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic signed [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] base_res;

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  assign shamt   = b[SHW-1:0];
  // Kept separate so the arithmetic shift is evaluated in a signed context.
  assign sra_res = $signed(a) >>> shamt;

  // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
  always_comb begin
    base_res = '0;
    case (alu_ctrl[2:0])
      F3_ADD:  base_res = alu_ctrl[3] ? (a - b) : (a + b);
      F3_SLL:  base_res = a << shamt;
      F3_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      F3_SLTU: base_res = {{(WIDTH-1){1'b0}}, a < b};
      F3_XOR:  base_res = a ^ b;
      F3_SR:   base_res = alu_ctrl[3] ? sra_res : (a >> shamt);
      F3_OR:   base_res = a | b;
      F3_AND:  base_res = a & b;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MULTICYCLE_MULDIV_EN
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_result;
  logic             div_by_zero, div_ovf, div_special;
  logic [WIDTH-1:0] special_res;

  // Divide-by-zero and signed overflow bypass the engine and finish like base ops.
  always_comb begin
    div_by_zero = (b == '0);
    div_ovf     = !alu_ctrl[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    div_special = alu_ctrl[2] && (div_by_zero || div_ovf);
    if (div_by_zero)
      special_res = alu_ctrl[1] ? a : '1;
    else
      special_res = alu_ctrl[1] ? '0 : a;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .start  (md_start),
    .op     (alu_ctrl[2:0]),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef ALU_MULTICYCLE_MULDIV_EN
    md_start  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          illegal_d = 1'b0;
          state_d   = ST_DONE;
          if (!m_op) begin
            result_d = base_res;
          end else begin
`ifdef ALU_MULTICYCLE_MULDIV_EN
            if (div_special) begin
              result_d = special_res;
            end else begin
              md_start = 1'b1;
              state_d  = ST_BUSY;
            end
`else
            result_d  = '0;
            illegal_d = 1'b1;
`endif
          end
        end
      end
      ST_BUSY: begin
`ifdef ALU_MULTICYCLE_MULDIV_EN
        if (md_done) begin
          result_d = md_result;
          state_d  = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
    zero_d = (result_d == '0);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed, table-driven bench for alu_multicycle (WIDTH=32); expectations adapt to whether
// ALU_MULTICYCLE_MULDIV_EN is defined (M ops otherwise complete at once as illegal).
module tb_alu_multicycle;

  localparam int W = 32;
`ifdef ALU_MULTICYCLE_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct {
    string          name;
    logic           m;
    logic [3:0]     ctrl;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   exp;
    int             lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_ctrl = '0;
  logic         m_op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_ctrl  (alu_ctrl),
    .m_op      (m_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // M ops are expected to come back immediately as illegal with result 0 when the feature is absent.
  function automatic vec_t mk(input string name, input logic m, input logic [3:0] ctrl,
                              input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] ev, input int lat);
    vec_t v;
    v.name = name; v.m = m; v.ctrl = ctrl; v.a = av; v.b = bv;
    v.exp  = (m && !MD_EN) ? '0 : ev;
    v.lat  = (m && !MD_EN) ? 1 : lat;
    return v;
  endfunction

  task automatic issue(input vec_t v);
    @(negedge clk);
    check({v.name, " in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; m_op = v.m; alu_ctrl = v.ctrl; a = v.a; b = v.b;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~v.a; b = ~v.b; alu_ctrl = ~v.ctrl;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check({name, " out_valid after consume"}, W'(out_valid), W'(0));
    check({name, " in_ready after consume"}, W'(in_ready), W'(1));
  endtask

  task automatic run_op(input vec_t v);
    int n;
    issue(v);
    wait_valid(n);
    check({v.name, " latency"}, W'(n), W'(v.lat));
    check({v.name, " result"}, result, v.exp);
    check({v.name, " zero"}, W'(zero), W'(v.exp == '0));
    check({v.name, " illegal"}, W'(illegal), W'(v.m && !MD_EN));
    check({v.name, " in_ready in DONE"}, W'(in_ready), W'(0));
    consume(v.name);
  endtask

  task automatic check_reset_values(input string name);
    check({name, " out_valid"}, W'(out_valid), W'(0));
    check({name, " result"}, result, '0);
    check({name, " zero"}, W'(zero), W'(1));
    check({name, " illegal"}, W'(illegal), W'(0));
    check({name, " in_ready"}, W'(in_ready), W'(1));
  endtask

  task automatic count_spurious(input string name);
    int hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check({name, " spurious out_valid"}, W'(hits), W'(0));
  endtask

  initial begin
    vec_t v;
    int   n;

    vecs.push_back(mk("ADD",        1'b0, 4'b0000, 32'd5,        32'd7,        32'd12,       1));
    vecs.push_back(mk("SUB eq",     1'b0, 4'b1000, 32'h10,       32'h10,       32'h0,        1));
    vecs.push_back(mk("SUB wrap",   1'b0, 4'b1000, 32'h0,        32'h1,        32'hFFFFFFFF, 1));
    vecs.push_back(mk("ADD wrap",   1'b0, 4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        1));
    vecs.push_back(mk("SLL mask",   1'b0, 4'b0001, 32'h1,        32'h23,       32'h8,        1));
    vecs.push_back(mk("SLT",        1'b0, 4'b0010, 32'hFFFFFFFF, 32'h1,        32'h1,        1));
    vecs.push_back(mk("SLTU",       1'b0, 4'b0011, 32'hFFFFFFFF, 32'h1,        32'h0,        1));
    vecs.push_back(mk("SLTU lt",    1'b0, 4'b0011, 32'h1,        32'hFFFFFFFF, 32'h1,        1));
    vecs.push_back(mk("XOR",        1'b0, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1));
    vecs.push_back(mk("SRL",        1'b0, 4'b0101, 32'h80000000, 32'h4,        32'h08000000, 1));
    vecs.push_back(mk("SRA",        1'b0, 4'b1101, 32'h80000000, 32'h4,        32'hF8000000, 1));
    vecs.push_back(mk("SRA 31",     1'b0, 4'b1101, 32'h80000000, 32'h3F,       32'hFFFFFFFF, 1));
    vecs.push_back(mk("OR",         1'b0, 4'b0110, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1));
    vecs.push_back(mk("AND",        1'b0, 4'b0111, 32'hFFFF0000, 32'h0FF00FF0, 32'h0FF00000, 1));
    vecs.push_back(mk("DIV",        1'b1, 4'b0100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33));
    vecs.push_back(mk("REM",        1'b1, 4'b0110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33));
    vecs.push_back(mk("DIVU by 0",  1'b1, 4'b0101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1));
    vecs.push_back(mk("REMU by 0",  1'b1, 4'b0111, 32'h1234,     32'h0,        32'h1234,     1));
    vecs.push_back(mk("DIV ovf",    1'b1, 4'b0100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
    vecs.push_back(mk("REM ovf",    1'b1, 4'b0110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk("DIVU alt",   1'b1, 4'b1101, 32'd100,      32'd7,        32'd14,       33));
    vecs.push_back(mk("REMU",       1'b1, 4'b0111, 32'd100,      32'd7,        32'd2,        33));
    vecs.push_back(mk("DIV neg",    1'b1, 4'b0100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33));
    vecs.push_back(mk("REM neg",    1'b1, 4'b0110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33));
    vecs.push_back(mk("MUL",        1'b1, 4'b0000, 32'h80000000, 32'h80000000, 32'h0,        33));
    vecs.push_back(mk("MULH",       1'b1, 4'b0001, 32'h80000000, 32'h80000000, 32'h40000000, 33));
    vecs.push_back(mk("MULHU",      1'b1, 4'b0011, 32'h80000000, 32'h80000000, 32'h40000000, 33));
    vecs.push_back(mk("MULHSU",     1'b1, 4'b0010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 33));
    vecs.push_back(mk("MUL neg",    1'b1, 4'b0000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    foreach (vecs[i]) run_op(vecs[i]);

    // Result held while out_ready is low; new requests and operand changes are ignored.
    v = mk("hold", 1'b0, 4'b0000, 32'd3, 32'd4, 32'd7, 1);
    issue(v);
    wait_valid(n);
    check("hold latency", W'(n), W'(1));
    in_valid = 1'b1; m_op = 1'b0; alu_ctrl = 4'b0000; a = 32'd99; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold result", result, 32'd7);
      check("hold out_valid", W'(out_valid), W'(1));
      check("hold in_ready", W'(in_ready), W'(0));
    end
    consume("hold");

    // Flush ten cycles after acceptance, together with out_ready and a new request.
    v = mk("flush busy", 1'b1, 4'b0101, 32'd100, 32'd7, 32'd14, 33);
    issue(v);
    repeat (10) @(negedge clk);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    m_op = 1'b0; alu_ctrl = 4'b0000; a = 32'd1; b = 32'd1;
    #1;
    check("flush in_ready gated", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush out_valid", W'(out_valid), W'(0));
    check("flush in_ready next", W'(in_ready), W'(1));
    count_spurious("flush");

    // Flush in IDLE beats a simultaneous request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    check("idle flush in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle flush no accept", W'(out_valid), W'(0));

    // Reset five cycles after an M op is accepted, then the engine must run a clean op.
    v = mk("reset mid", 1'b1, 4'b0011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    issue(v);
    repeat (5) @(negedge clk);
    check("pre-reset out_valid", W'(out_valid), W'(!MD_EN));
    check("pre-reset illegal", W'(illegal), W'(!MD_EN));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset mid");
    count_spurious("reset mid");
    run_op(v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
